ysyx_23060332_dmem_resp: RTL

Data-memory responder for the `ysyx_23060332` core: the slave end of the load/store interface driven by the execute unit. Accepts one read or write request at a time and applies byte-masked writes to an internal 64-bit-wide storage array. Returns read data or a write acknowledge after a programmable latency, and holds each response until the requester takes it. Sits between the EXU memory port and the rest of the system; it replaces the ideal zero-latency memory model used in simulation.

---
 rtl/ysyx_23060332_dmem_resp_if.sv | 25 ++
 rtl/ysyx_23060332_dmem_resp.sv | 107 ++++++++++
 2 files changed

// File: rtl/ysyx_23060332_dmem_resp_if.sv
// Load/store port between the EXU (master) and the data-memory responder (slave).
interface ysyx_23060332_dmem_resp_if;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic        mem_wen;
  logic [31:0] mem_waddr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [63:0] mem_rdata;
  logic        mem_rwrite;
  logic        mem_err;

  modport master (
    output mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_rready,
    input  mem_ready, mem_rvalid, mem_rdata, mem_rwrite, mem_err
  );

  modport slave (
    input  mem_ren, mem_raddr, mem_wen, mem_waddr, mem_wdata, mem_wmask, mem_rready,
    output mem_ready, mem_rvalid, mem_rdata, mem_rwrite, mem_err
  );
endinterface

// File: rtl/ysyx_23060332_dmem_resp.sv
// Data-memory responder: one request at a time, byte-masked 64-bit array,
// response after LATENCY cycles and held until the requester takes it.
module ysyx_23060332_dmem_resp #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060332_dmem_resp_if.slave bus
);
  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  WAIT     = 2'd1;
  localparam logic [1:0]  RESP     = 2'd2;
  localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
  localparam logic [32:0] SPAN     = 33'(WORDS) << 3;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [63:0] mem [WORDS];
  logic [63:0] rdata_q;
  logic        rwrite_q;
  logic        err_q;

  logic [31:0]           roff, woff;
  logic                  r_oob, w_oob;
  logic [DEPTH_LOG2-1:0] ridx, widx;
  logic                  accept, take;
  logic                  unused_addr_bits;

  // Addresses below BASE_ADDR wrap to huge offsets and fall out of range.
  assign roff  = bus.mem_raddr - BASE_ADDR;
  assign woff  = bus.mem_waddr - BASE_ADDR;
  assign r_oob = {1'b0, roff} >= SPAN;
  assign w_oob = {1'b0, woff} >= SPAN;
  assign ridx  = roff[DEPTH_LOG2+2:3];
  assign widx  = woff[DEPTH_LOG2+2:3];
  assign unused_addr_bits = ^{roff[31:DEPTH_LOG2+3], roff[2:0],
                              woff[31:DEPTH_LOG2+3], woff[2:0]};

  assign accept = rst_n && (state == IDLE) && (bus.mem_ren || bus.mem_wen);
  assign take   = (state == RESP) && bus.mem_rready;

  assign bus.mem_ready  = (state == IDLE);
  assign bus.mem_rvalid = (state == RESP);
  assign bus.mem_rdata  = rdata_q;
  assign bus.mem_rwrite = rwrite_q;
  assign bus.mem_err    = err_q;

  // Storage is deliberately not reset; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (accept && bus.mem_wen && !w_oob) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.mem_wmask[i]) mem[widx][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      rdata_q  <= 64'd0;
      rwrite_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            // A simultaneous read is dropped and flagged on the write ack.
            rwrite_q <= bus.mem_wen;
            err_q    <= bus.mem_wen ? (w_oob || bus.mem_ren) : r_oob;
            rdata_q  <= (bus.mem_wen || r_oob) ? 64'd0 : mem[ridx];
            if (LATENCY == 1) begin
              state <= RESP;
              cnt   <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (take) begin
            state    <= IDLE;
            rdata_q  <= 64'd0;
            rwrite_q <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 4'd0;
        end
      endcase
    end
  end
endmodule
